// File: rtl/lcd12864_pkg.sv
// Shared opcode masks, row base addresses, FSM states and decode helpers for
// the LCD12864 (ST7920-style) bus receiver.
package lcd12864_pkg;

  localparam logic [7:0] LCD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_HOME    = 8'h02;
  localparam logic [7:0] LCD_ENTRY   = 8'h04;
  localparam logic [7:0] LCD_DISPCTL = 8'h08;
  localparam logic [7:0] LCD_SHIFT   = 8'h10;
  localparam logic [7:0] LCD_FUNC    = 8'h20;
  localparam logic [7:0] LCD_CGRAM   = 8'h40;
  localparam logic [7:0] LCD_DDRAM   = 8'h80;

  localparam logic [7:0] LCD_ROW0 = 8'h80;
  localparam logic [7:0] LCD_ROW1 = 8'h90;
  localparam logic [7:0] LCD_ROW2 = 8'h88;
  localparam logic [7:0] LCD_ROW3 = 8'h98;

  localparam logic [7:0] LCD_BLANK     = 8'h20;
  localparam int         LCD_MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_RESET_FILL,
    ST_IDLE,
    ST_FILL
  } lcd_state_t;

  typedef enum logic [3:0] {
    OP_NONE, OP_CLEAR, OP_HOME, OP_ENTRY, OP_DISPCTL,
    OP_SHIFT, OP_FUNC, OP_CGRAM, OP_DDRAM
  } lcd_op_t;

  // Instruction class is selected by the highest set bit of the byte.
  function automatic lcd_op_t lcd_decode(input logic [7:0] b);
    if ((b & LCD_DDRAM) != 8'h00)        return OP_DDRAM;
    else if ((b & LCD_CGRAM) != 8'h00)   return OP_CGRAM;
    else if ((b & LCD_FUNC) != 8'h00)    return OP_FUNC;
    else if ((b & LCD_SHIFT) != 8'h00)   return OP_SHIFT;
    else if ((b & LCD_DISPCTL) != 8'h00) return OP_DISPCTL;
    else if ((b & LCD_ENTRY) != 8'h00)   return OP_ENTRY;
    else if ((b & LCD_HOME) != 8'h00)    return OP_HOME;
    else if ((b & LCD_CLEAR) != 8'h00)   return OP_CLEAR;
    else                                 return OP_NONE;
  endfunction

  function automatic logic [5:0] lcd_ac_step(input logic [5:0] ac, input logic up);
    return up ? ac + 6'd1 : ac - 6'd1;
  endfunction

endpackage

// File: rtl/lcd12864_bus_rx_if.sv
// Host-side LCD12864 parallel write bus: the host drives it (master), the
// receiver samples it (slave).
interface lcd12864_bus_rx_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_dat;

  modport master (output lcd_rs, lcd_rw, lcd_en, lcd_dat);
  modport slave  (input  lcd_rs, lcd_rw, lcd_en, lcd_dat);
endinterface

// File: rtl/lcd12864_bus_sync.sv
// Two-flop synchronizer for {en,rs,rw,dat} plus a falling-edge pulse on en;
// rs/rw/dat are presented from the same stage the edge is detected on.
module lcd12864_bus_sync (
  input  logic                    clk,
  input  logic                    rst_n,
  lcd12864_bus_rx_if.slave        bus,
  output logic                    en_fall,
  output logic                    rs,
  output logic                    rw,
  output logic [7:0]              dat
);
  localparam int W = 11;

  logic [W-1:0] raw;
  logic [W-1:0] synced;
  logic         en_d_reg;

  assign raw = {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_dat};

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign synced[gi] = s2_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_d_reg <= 1'b0;
    else        en_d_reg <= synced[10];
  end

  assign en_fall       = en_d_reg & ~synced[10];
  assign {rs, rw, dat} = synced[9:0];
endmodule

// File: rtl/lcd12864_bus_rx.sv
// LCD12864 write-bus receiver: decodes the basic instruction set into a
// 64-byte DDRAM image. Optional drop counter: LCD12864_RX_DROP_CNT_EN.
module lcd12864_bus_rx
  import lcd12864_pkg::*;
#(
  parameter int CLEAR_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lcd12864_bus_rx_if.slave        bus,
  input  logic [1:0]              rd_row,
  input  logic [3:0]              rd_col,
  output logic [7:0]              rd_data,
  output logic                    busy,
  output logic                    disp_on,
  output logic                    cursor_on,
  output logic                    blink_on,
  output logic                    ext_mode,
  output logic [5:0]              ac,
  output logic                    cmd_valid,
  output logic                    cmd_rs,
  output logic [7:0]              cmd_byte,
  output logic                    drop
`ifdef LCD12864_RX_DROP_CNT_EN
  , output logic [7:0]            drop_cnt
`endif
);
  localparam int CW = $clog2(CLEAR_CYCLES);

  logic            en_fall, s_rs, s_rw;
  logic [7:0]      s_dat;
  lcd_state_t      state_reg;
  logic [CW-1:0]   fill_cnt_reg;
  logic            id_reg;
  logic            filling, fill_last, gate, exec, drop_ev;
  logic            mem_we;
  logic [5:0]      mem_waddr;
  logic [7:0]      mem_wdata;
  lcd_op_t         op;
  logic [7:0]      mem [0:LCD_MEM_DEPTH-1];

  lcd12864_bus_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .en_fall (en_fall),
    .rs      (s_rs),
    .rw      (s_rw),
    .dat     (s_dat)
  );

  // busy lags the state by a cycle; gating on both covers the whole window.
  assign filling   = (state_reg != ST_IDLE);
  assign fill_last = (fill_cnt_reg == CW'(CLEAR_CYCLES - 1));
  assign gate      = filling | busy;
  assign exec      = en_fall & ~gate & ~s_rw;
  assign drop_ev   = en_fall & (gate | s_rw);
  assign op        = lcd_decode(s_dat);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ac;
    mem_wdata = s_dat;
    if (filling) begin
      mem_we    = (int'(fill_cnt_reg) < LCD_MEM_DEPTH);
      mem_waddr = fill_cnt_reg[5:0];
      mem_wdata = LCD_BLANK;
    end else if (exec && s_rs && !ext_mode) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Rows 1 and 2 are interleaved in DDRAM, hence the swapped row bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= mem[{rd_row[0], rd_row[1], rd_col}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RESET_FILL;
      fill_cnt_reg <= '0;
      busy         <= 1'b1;
      id_reg       <= 1'b1;
      ac           <= 6'd0;
      ext_mode     <= 1'b0;
      disp_on      <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_rs       <= 1'b0;
      cmd_byte     <= 8'h00;
      drop         <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      drop      <= drop_ev;
      busy      <= filling;

      case (state_reg)
        ST_RESET_FILL, ST_FILL: begin
          if (fill_last) state_reg <= ST_IDLE;
          else           fill_cnt_reg <= fill_cnt_reg + 1'b1;
        end
        default: ;
      endcase

      if (exec) begin
        cmd_valid <= 1'b1;
        cmd_rs    <= s_rs;
        cmd_byte  <= s_dat;
        if (s_rs) begin
          if (!ext_mode) ac <= lcd_ac_step(ac, id_reg);
        end else if (op == OP_FUNC) begin
          ext_mode <= s_dat[2];
        end else if (!ext_mode) begin
          case (op)
            OP_DDRAM:   ac <= {s_dat[4:0], 1'b0};
            OP_SHIFT:   if (!s_dat[3]) ac <= lcd_ac_step(ac, s_dat[2]);
            OP_DISPCTL: begin
              disp_on   <= s_dat[2];
              cursor_on <= s_dat[1];
              blink_on  <= s_dat[0];
            end
            OP_ENTRY:   id_reg <= s_dat[1];
            OP_HOME:    ac <= 6'd0;
            OP_CLEAR: begin
              ac           <= 6'd0;
              id_reg       <= 1'b1;
              state_reg    <= ST_FILL;
              fill_cnt_reg <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef LCD12864_RX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_cnt <= 8'h00;
    else if (drop_ev && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_lcd12864_bus_rx.sv
// Directed bench for lcd12864_bus_rx: strobes bytes onto the bus and checks
// flags, address counter, pulses and DDRAM contents against hand-worked values.
module tb_lcd12864_bus_rx;
  import lcd12864_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rd_row = 2'd0;
  logic [3:0] rd_col = 4'd0;
  logic [7:0] rd_data;
  logic       busy, disp_on, cursor_on, blink_on, ext_mode;
  logic [5:0] ac;
  logic       cmd_valid, cmd_rs, drop;
  logic [7:0] cmd_byte;
`ifdef LCD12864_RX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  lcd12864_bus_rx_if bus ();

  lcd12864_bus_rx #(.CLEAR_CYCLES(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .busy      (busy),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .ext_mode  (ext_mode),
    .ac        (ac),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_byte  (cmd_byte),
    .drop      (drop)
`ifdef LCD12864_RX_DROP_CNT_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // en high for 16 clk, then wait up to 8 clk for cmd_valid or drop.
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d,
                        output logic got_valid, output logic got_drop);
    bus.lcd_rs  = rs;
    bus.lcd_rw  = rw;
    bus.lcd_dat = d;
    bus.lcd_en  = 1'b1;
    repeat (16) @(negedge clk);
    bus.lcd_en = 1'b0;
    got_valid = 1'b0;
    got_drop  = 1'b0;
    for (int i = 0; i < 8 && !got_valid && !got_drop; i++) begin
      @(negedge clk);
      got_valid = cmd_valid;
      got_drop  = drop;
    end
    $display("strobe rs=%0d rw=%0d dat=%02h -> valid=%0d drop=%0d ac=%0d",
             rs, rw, d, got_valid, got_drop, ac);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    logic v, dr;
    strobe(rs, 1'b0, d, v, dr);
    check($sformatf("accept_%0d_%02h", rs, d), {dr, v}, 2'b01);
    repeat (8) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] r, input logic [3:0] c, output logic [7:0] d);
    rd_row = r;
    rd_col = c;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       v, dr;
    int         n;
    string      hello;

    bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_dat = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    check("rst_ac", ac, 6'd0);
    check("rst_flags", {disp_on, cursor_on, blink_on, ext_mode}, 4'b0000);
    check("rst_cmd", {cmd_valid, cmd_rs, drop, cmd_byte}, 11'd0);
    check("rst_rd_data", rd_data, 8'h00);

    // Reset fill, then every cell is blank
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_fill_len_ok", (n >= 64 && n <= 66), 1'b1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++) begin
        rd(r[1:0], c[3:0], d);
        check($sformatf("blank_r%0d_c%0d", r, c), d, LCD_BLANK);
      end

    // Init sequence; clear busy timing measured from cmd_valid
    wr(1'b0, 8'h30);
    wr(1'b0, 8'h0C);
    wr(1'b0, 8'h06);
    check("flags_0c", {disp_on, cursor_on, blink_on}, 3'b100);
    strobe(1'b0, 1'b0, 8'h01, v, dr);
    check("clear_valid", v, 1'b1);
    check("clear_busy_same_cycle", busy, 1'b0);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("clear_busy_len", n, 64);
    check("clear_ac", ac, 6'd0);

    // HELLO on row 1
    hello = "HELLO";
    wr(1'b0, LCD_ROW1);
    check("ac_row1", ac, 6'd32);
    for (int i = 0; i < 5; i++) wr(1'b1, hello[i]);
    check("ac_hello", ac, 6'd37);
    for (int i = 0; i < 5; i++) begin
      rd(2'd1, i[3:0], d);
      check($sformatf("hello_c%0d", i), d, hello[i]);
    end

    // Row 3 wraps back to physical 0
    wr(1'b0, LCD_ROW3);
    check("ac_row3", ac, 6'd48);
    for (int i = 0; i < 17; i++) wr(1'b1, 8'h61 + 8'(i));
    check("ac_wrap", ac, 6'd1);
    rd(2'd3, 4'd0, d);  check("row3_c0", d, 8'h61);
    rd(2'd3, 4'd15, d); check("row3_c15", d, 8'h70);
    rd(2'd0, 4'd0, d);  check("wrap_row0_c0", d, 8'h71);
    rd(2'd0, 4'd1, d);  check("row0_c1_blank", d, LCD_BLANK);

    // rw=1 is dropped
    strobe(1'b1, 1'b1, 8'h55, v, dr);
    check("rw_drop", {dr, v}, 2'b10);
    repeat (8) @(negedge clk);
    check("rw_drop_ac", ac, 6'd1);
    rd(2'd0, 4'd1, d); check("rw_drop_mem", d, LCD_BLANK);
`ifdef LCD12864_RX_DROP_CNT_EN
    check("drop_cnt_1", drop_cnt, 8'd1);
`endif

    // Strobe during busy is dropped
    strobe(1'b0, 1'b0, 8'h01, v, dr);
    check("clear2_valid", v, 1'b1);
    strobe(1'b1, 1'b0, 8'h77, v, dr);
    check("busy_drop", {dr, v}, 2'b10);
    wait_not_busy("clear2_done");
    check("busy_drop_ac", ac, 6'd0);
    rd(2'd0, 4'd0, d); check("busy_drop_mem", d, LCD_BLANK);
`ifdef LCD12864_RX_DROP_CNT_EN
    check("drop_cnt_2", drop_cnt, 8'd2);
`endif

    // Extended mode only honours function set
    wr(1'b0, 8'h08);
    check("flags_off", {disp_on, cursor_on, blink_on}, 3'b000);
    wr(1'b0, 8'h34);
    check("ext_on", ext_mode, 1'b1);
    wr(1'b0, 8'h0F);
    check("ext_flags_held", {disp_on, cursor_on, blink_on}, 3'b000);
    wr(1'b1, 8'h41);
    check("ext_data_ac", ac, 6'd0);
    rd(2'd0, 4'd0, d); check("ext_data_mem", d, LCD_BLANK);
    wr(1'b0, 8'h30);
    check("ext_off", ext_mode, 1'b0);
    wr(1'b0, 8'h0F);
    check("flags_0f", {disp_on, cursor_on, blink_on}, 3'b111);

    // Entry decrement, row 2 mapping, shift and home
    wr(1'b0, 8'h04);
    wr(1'b0, LCD_ROW0);
    wr(1'b1, 8'h5A);
    check("dec_ac", ac, 6'd63);
    rd(2'd0, 4'd0, d); check("dec_mem", d, 8'h5A);
    wr(1'b0, 8'h06);
    wr(1'b0, LCD_ROW2);
    check("ac_row2", ac, 6'd16);
    wr(1'b1, 8'h51);
    rd(2'd2, 4'd0, d); check("row2_c0", d, 8'h51);
    check("cmd_byte_last", {cmd_rs, cmd_byte}, 9'h151);
    wr(1'b0, 8'h14);
    check("shift_right", ac, 6'd18);
    wr(1'b0, 8'h10);
    check("shift_left", ac, 6'd17);
    wr(1'b0, 8'h1C);
    check("shift_disp_ignored", ac, 6'd17);
    wr(1'b0, 8'h02);
    check("home", ac, 6'd0);

    // Reset during a fill aborts; fill restarts after release
    strobe(1'b0, 1'b0, 8'h01, v, dr);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", busy, 1'b1);
    check("midrst_state", {disp_on, cursor_on, blink_on, ext_mode, ac}, 10'd0);
    check("midrst_cmd", {cmd_valid, cmd_rs, cmd_byte, rd_data}, 17'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wait_not_busy("midrst_fill_done");
    rd(2'd2, 4'd0, d); check("midrst_mem", d, LCD_BLANK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lcd12864_bus_rx.md
# lcd12864_bus_rx

Receiving end of the LCD12864 (ST7920-style) 8-bit parallel write bus. It samples the host's `rs/rw/en/dat` lines in the system clock domain and decodes the basic instruction set. It maintains a 64-byte DDRAM image and display-control flags, and exposes a row/column read port for a display mirror or checker. It sits opposite our panel-driving controllers, either in place of the physical panel or tapped onto the same pins.

## Interface
Parameters:
- `CLEAR_CYCLES`, default 64: busy duration of a clear or reset fill, one DDRAM byte per cycle. Must be ≥ 64.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `lcd_rs` in 1: register select. 0 = instruction, 1 = data.
- `lcd_rw` in 1: 0 = write. Strobes with 1 are not executed.
- `lcd_en` in 1: enable strobe, asynchronous to `clk`. Byte is latched on its falling edge.
- `lcd_dat` in 8: bus data.
- `rd_row` in 2: logical display row for the read port.
- `rd_col` in 4: column within the row.
- `rd_data` out 8: DDRAM byte at (`rd_row`, `rd_col`). Registered.
- `busy` out 1: clear/fill in progress.
- `disp_on`, `cursor_on`, `blink_on` out 1 each: display control flags.
- `ext_mode` out 1: extended instruction set selected (RE=1).
- `ac` out 6: address counter, as a byte address.
- `cmd_valid` out 1: one-cycle pulse per accepted strobe.
- `cmd_rs` out 1, `cmd_byte` out 8: the captured strobe. Valid while `cmd_valid` is high.
- `drop` out 1: one-cycle pulse when a strobe arrives during `busy` or with `lcd_rw=1`.

## Operation
**Capture**
- `lcd_en`, `lcd_rs`, `lcd_rw` and `lcd_dat` pass through two synchronizer flops.
- A third flop on `en` detects the falling edge.
- `rs/rw/dat` are taken from the same synchronizer stage as the edge.

**Gating**
- A strobe with `rw=1` or during `busy` produces `drop` only. It has no other effect.
- Otherwise `cmd_valid` pulses and the strobe executes in the same cycle.

**Data writes (`rs=1`)**
- Write `mem[ac] <= byte`.
- Then `ac <= ac±1` (mod 64). `+1` when `id=1`, `−1` when `id=0`.

**Instructions (`rs=0`), decoded on the highest set bit:**
- `0x01` clear: `ac<=0`, `id<=1`, enter FILL.
- `0x02/0x03` home: `ac<=0`.
- `0x04–0x07` entry mode: `id<=dat[1]`. The shift bit is ignored.
- `0x08–0x0F` display control: `disp_on<=dat[2]`, `cursor_on<=dat[1]`, `blink_on<=dat[0]`.
- `0x10–0x1F` cursor/display shift: `dat[3]=0` moves `ac` by ±1 according to `dat[2]`. `dat[3]=1` is ignored.
- `0x20–0x3F` function set: `ext_mode<=dat[2]`. DL is ignored (8-bit only).
- `0x40–0x7F` CGRAM: accepted, no effect.
- `0x80–0xFF` set DDRAM address: `ac <= {dat[4:0],1'b0}`. For example `0x90` gives 32, `0x88` gives 16, `0x98` gives 48.

**Extended mode**
- While `ext_mode=1`, only function set executes.
- All other instructions and data writes still pulse `cmd_valid` but have no effect.

**Read mapping**
- Physical index is `{rd_row[0], rd_row[1], rd_col}`: row0→0, row1→32, row2→16, row3→48.

**FSM states**
- RESET_FILL → IDLE, after `CLEAR_CYCLES` cycles.
- IDLE → FILL on a clear instruction.
- FILL → IDLE after `CLEAR_CYCLES` cycles.
- FILL writes `0x20` to `mem[fill_cnt]` for `fill_cnt` 0..63. `busy=1` in both fill states.

## Timing
- Falling edge of `lcd_en` to `cmd_valid` and its effect: 3–4 `clk` cycles, depending on synchronizer phase.
- `lcd_en` high and low times must each be ≥ 3 `clk`. `rs/rw/dat` must be stable from 3 `clk` before to 1 `clk` after the falling edge.
- `rd_data` has 1-cycle latency from `rd_row/rd_col`. A read and a write to the same address in the same cycle return the old byte.
- `busy` rises in the cycle after the clear's `cmd_valid`. It falls exactly `CLEAR_CYCLES` cycles later.
- Reset values:
  - `ac=0`, `id=1`, `ext_mode=0`.
  - `disp_on`, `cursor_on`, `blink_on` = 0.
  - `cmd_valid`, `drop`, `cmd_rs` = 0; `cmd_byte=0x00`; `rd_data=0x00`; synchronizers 0.
  - FSM in RESET_FILL, `busy=1`.
- Reset asserted mid-FILL or mid-strobe aborts everything. The fill restarts from 0 after release.
- An edge on the last FILL cycle is dropped.

## Configuration
- `LCD12864_RX_DROP_CNT_EN` defined: adds output `drop_cnt` (out, 8 bits). It increments on every `drop` pulse, saturates at 255, and resets to 0.
- Macro undefined: the port and counter are absent. `drop` is unchanged.

## Structure
- Shared package `lcd12864_pkg`:
  - Opcode masks/constants: `LCD_CLEAR`, `LCD_HOME`, `LCD_ENTRY`, `LCD_DISPCTL`, `LCD_SHIFT`, `LCD_FUNC`, `LCD_CGRAM`, `LCD_DDRAM`.
  - Row base addresses 0x80/0x90/0x88/0x98.
  - Blank char 0x20.
  - FSM state enum.
- Sub-module `lcd12864_bus_sync`: 2-flop synchronizer for `{en,rs,rw,dat}` plus the falling-edge pulse.

## Test plan
- Release reset, wait 64 cycles: `busy` falls. All 64 `rd_data` reads return 0x20.
- Strobes 0x30, 0x0C, 0x06, 0x01 (rs=0), en period 32 clk → four `cmd_valid` pulses; `disp_on=1`, `cursor_on=0`, `blink_on=0`; `busy` high for 64 cycles.
- After fill: 0x90 then "HELLO" (rs=1) → row1 col0–4 read "HELLO"; `ac=37`.
- 0x98 followed by 17 data bytes: `ac` wraps 63→0, and the 17th byte lands at physical 0 (row0 col0).
- Strobe during `busy`, or with `rw=1` → `drop` pulses, no memory change. With the macro defined, `drop_cnt=1`.
- 0x34 then 0x0F then 0x30: `ext_mode` goes 1 then 0; display flags stay 0 after the 0x0F.
